// File: rtl/arb_pkg.sv
// Shared arbiter definitions: port count, source index width and
// one-hot helpers used by the arbiter, its output FIFO and their benches.
package arb_pkg;

  localparam int NPORT_DEF = 5;
  localparam int SRC_W     = 3;

  // True when exactly one bit of v is set
  function automatic logic is_onehot(input logic [NPORT_DEF-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Index of the set bit; only meaningful for a one-hot v
  function automatic logic [SRC_W-1:0] onehot_idx(
    input logic [NPORT_DEF-1:0] v
  );
    logic [SRC_W-1:0] r;
    r = '0;
    for (int i = 0; i < NPORT_DEF; i++) begin
      if (v[i]) r = SRC_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_fifo_mem.sv
// FIFO storage: register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module arb_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 35,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write the pushed entry at the write pointer
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/arb_out_fifo.sv
// Output buffer for the 5-way arbiter: captures the winning lane and its
// source into a FIFO, drains to a valid/ready consumer, drives wfull.
module arb_out_fifo
  import arb_pkg::*;
#(
  parameter int NPORT        = 5,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPORT-1:0]          arbitration,
  input  logic [NPORT*DATA_W-1:0]   in_data,
  output logic                      outfifo_wfull,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [DATA_W-1:0]         rd_data,
  output logic [SRC_W-1:0]          rd_src,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      err_onehot,
  output logic                      err_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = SRC_W + DATA_W;

  logic [NPORT_DEF-1:0] arb_v;
  logic                 oh;
  logic                 multi;
  logic [SRC_W-1:0]     src;
  logic [DATA_W-1:0]    lane;
  logic                 wfull_seen;
  logic                 push_req;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [EW-1:0]        head;

  assign arb_v    = NPORT_DEF'(arbitration);
  assign oh       = is_onehot(arb_v);
  assign multi    = (arb_v != '0) && !oh;
  assign src      = onehot_idx(arb_v);
  assign lane     = in_data[int'(src)*DATA_W +: DATA_W];

  assign full     = (count == CW'(DEPTH));
  assign rd_valid = (count != '0);
  assign pop      = rd_valid && rd_ready;
  // A stale vector held while the arbiter is frozen is never pushed
  assign push_req = oh && !wfull_seen;
  assign push     = push_req && (!full || pop);

  assign outfifo_wfull = (count >= CW'(DEPTH - AFULL_MARGIN));

  assign rd_src  = head[EW-1 -: SRC_W];
  assign rd_data = head[DATA_W-1:0];

  // Pointers and occupancy; count kept separately so full/empty is exact
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Delayed wfull copy matching what the arbiter acts on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wfull_seen <= 1'b0;
    else     wfull_seen <= outfifo_wfull;
  end

  // Sticky protocol error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_onehot   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (multi)                    err_onehot   <= 1'b1;
      if (push_req && full && !pop) err_overflow <= 1'b1;
    end
  end

  arb_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({src, lane}),
    .raddr (rd_ptr),
    .rdata (head)
  );

endmodule

// File: doc/arb_out_fifo.md
Name: arb_out_fifo

Overview:
- Output-side buffer that receives the one-hot `arbitration` vector from the 5-way least-recently-granted arbiter, together with the per-requester data lanes.
- Captures the winning lane's word and its source index into a FIFO, and drains the FIFO to a downstream valid/ready consumer.
- Generates the `outfifo_wfull` back-pressure signal that freezes the arbiter. It is the consumer end of the arbiter's arbitration/wfull interface.

Parameters:
- NPORT, 5: number of requesters; `arbitration` width.
- DATA_W, 32: width of each requester data lane and of `rd_data`.
- DEPTH, 8: FIFO entries; power of 2, minimum 4.
- AFULL_MARGIN, 1: free-slot margin at which `outfifo_wfull` asserts; covers the arbiter's one-cycle registered view of wfull.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset: one clock; reset is asynchronous and active-high.
- arbitration  in  NPORT  one-hot winner from the arbiter; all-zero means no winner.
- in_data  in  NPORT*DATA_W  requester lanes; lane i occupies bits [i*DATA_W +: DATA_W].
- outfifo_wfull  out  1  back-pressure to the arbiter.
- rd_valid  out  1  head entry available.
- rd_ready  in  1  consumer accepts head.
- rd_data  out  DATA_W  head data.
- rd_src  out  3  head source index, 0..NPORT-1.
- count  out  clog2(DEPTH)+1  current occupancy.
- err_onehot  out  1  sticky: `arbitration` had more than one bit set.
- err_overflow  out  1  sticky: a push was attempted while count==DEPTH.

Behaviour:
- Reset (async, rst=1): pointers=0, count=0, rd_valid=0, outfifo_wfull=0, wfull_seen=0, both error flags=0. Asserting reset mid-operation discards all contents. Release takes effect at the next clk edge.
- wfull_seen is a register loaded each cycle with outfifo_wfull. It mirrors exactly the delayed copy the arbiter acts on.
- outfifo_wfull = (count >= DEPTH-AFULL_MARGIN). It is a decode of registered count only; there is no combinational path from any input.
- Push condition: arbitration is exactly one-hot AND wfull_seen==0.
  - While wfull_seen==1 the arbiter holds a stale vector; it is never pushed, so there are no duplicates.
  - On push, store {src=index of set bit, data=in_data lane[src]} at the write pointer, and advance the pointer modulo DEPTH.
- arbitration==0: no push, no error.
- arbitration with 2 or more bits set: no push, err_onehot<=1 (sticky until reset).
- Push condition true with count==DEPTH and no pop in the same cycle: entry dropped, err_overflow<=1. With AFULL_MARGIN>=1 this cannot occur under a compliant arbiter.
- Pop: when rd_valid && rd_ready, advance the read pointer modulo DEPTH.
- rd_valid = (count!=0). rd_data and rd_src are driven from the head entry.
- Push-to-read latency: 1 cycle. An entry pushed at edge N is visible on rd_* after edge N. There is no bypass when empty.
- Simultaneous push and pop: count unchanged and both pointers advance. Allowed at count==DEPTH (this does not set overflow).
- Pointer wrap: DEPTH-1 -> 0 on both pointers. Count is tracked separately, so full vs empty is unambiguous.
- Back-pressure timing with AFULL_MARGIN=1:
  - count reaches DEPTH-1 → outfifo_wfull=1.
  - Next cycle, wfull_seen is still 0 → one more push is allowed (count=DEPTH).
  - The cycle after that, wfull_seen=1 → pushes blocked.
- Deassertion: outfifo_wfull drops the cycle after count falls below DEPTH-AFULL_MARGIN. Pushes resume one cycle later.

Decomposition:
- Shared package `arb_pkg`:
  - NPORT_DEF=5 and SRC_W=3.
  - Function `onehot_idx` (one-hot to index).
  - Function `is_onehot`.
  - Both functions are reused by the arbiter testbench.
- Sub-module `arb_fifo_mem`: DEPTH x (SRC_W+DATA_W) register array with one write port and one asynchronous read port. It has no reset on the storage itself.
- Pointer, count, wfull and error logic live in the top module.

Test Plan:
- Reset then idle: arbitration=0 for 10 cycles -> count=0, rd_valid=0, outfifo_wfull=0, no error flags.
- Single push: arbitration=5'b00100, lane2=32'hA5A5_0002 -> next cycle rd_valid=1, rd_src=2, rd_data=32'hA5A5_0002. Pop with rd_ready=1 -> count back to 0.
- Fill with rd_ready=0, one-hot pushes every cycle (lanes 4,3,2,1,0,4,3,2): outfifo_wfull rises when count=7; exactly one more push gives count=8; the held arbitration vector is not pushed again; err_overflow stays 0.
- Drain and wrap: from full, pop 3 entries then push 3 -> order preserved across pointer wrap; outfifo_wfull drops the cycle after count=6.
- Simultaneous push+pop at count=4 for 6 cycles -> count stays 4; FIFO order matches push order.
- Illegal vector: arbitration=5'b10010 -> no push, err_onehot=1 and it stays set. Assert rst for one cycle mid-stream -> count=0, rd_valid=0, err_onehot=0 immediately (asynchronous).
